lsu: RTL and testbench

Parametrised load/store unit for the execute stage, replacing the single-cycle word-only memory path. Drives a valid/ready data-memory bus with wait states, supports byte/halfword/word accesses with lane steering and sign/zero extension, detects misaligned or illegal accesses, and aborts on bus timeout. It stalls the pipeline while a transfer is in flight and returns the load result with a one-cycle `done` pulse.

---
 rtl/lsu_if.sv | 21 ++
 rtl/lsu.sv | 174 +++++++++++++++++
 tb/tb_lsu.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - data-memory valid/ready bus between the lsu and memory
interface lsu_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_valid;
    logic                  mem_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_rdata;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_wstrb;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: sized, lane-steered accesses over a valid/ready bus with timeout
module lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hlt,
    input  logic        flush,
    input  logic        load,
    input  logic        store,
    input  logic [2:0]  funct3,
    input  logic [31:0] base,
    input  logic [31:0] offset,
    input  logic [31:0] wdata_in,
    output logic        stall,
    output logic        done,
    output logic [31:0] result,
    output logic        fault,
    output logic [1:0]  fault_cause,
    lsu_if.master       bus
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] T_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                state;
    logic [CW-1:0]         tcnt;
    logic [1:0]            off_q;
    logic [2:0]            f3_q;
    logic                  is_store_q;
    logic                  squash;
    logic                  valid_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;

    logic [31:0] addr_sum;
    logic        req;
    logic        illegal;
    logic        misaligned;
    logic        legal_req;
    logic        timeout_hit;
    logic [31:0] rd_shift;
    logic [31:0] ld_val;
    logic [31:0] st_data;
    logic [3:0]  st_strb;

    always_comb begin
        addr_sum   = base + offset;
        req        = (load | store) & ~flush & ~hlt;
        if (store)
            illegal = ~(funct3 inside {3'd0, 3'd1, 3'd2});
        else
            illegal = ~(funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        misaligned = ((funct3[1:0] == 2'd1) & addr_sum[0]) |
                     ((funct3[1:0] == 2'd2) & (|addr_sum[1:0]));
        legal_req  = req & ~illegal & ~misaligned;
        stall      = (state == BUSY) | ((state == IDLE) & legal_req);
        // a ready in the last allowed cycle completes normally
        timeout_hit = (TIMEOUT != 0) && (tcnt == T_LAST) && !bus.mem_ready;
    end

    always_comb begin
        st_data = wdata_in;
        st_strb = 4'b1111;
        case (funct3[1:0])
            2'd0: begin
                st_data = {4{wdata_in[7:0]}};
                st_strb = 4'b0001 << addr_sum[1:0];
            end
            2'd1: begin
                st_data = {2{wdata_in[15:0]}};
                st_strb = 4'b0011 << addr_sum[1:0];
            end
            default: begin
                st_data = wdata_in;
                st_strb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        rd_shift = bus.mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'd0:    ld_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'd1:    ld_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'd4:    ld_val = {24'd0, rd_shift[7:0]};
            3'd5:    ld_val = {16'd0, rd_shift[15:0]};
            default: ld_val = rd_shift;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            tcnt        <= '0;
            off_q       <= '0;
            f3_q        <= '0;
            is_store_q  <= 1'b0;
            squash      <= 1'b0;
            valid_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            done        <= 1'b0;
            result      <= '0;
            fault       <= 1'b0;
            fault_cause <= '0;
        end else begin
            fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (req && illegal) begin
                        fault       <= 1'b1;
                        fault_cause <= 2'd2;
                    end else if (req && misaligned) begin
                        fault       <= 1'b1;
                        fault_cause <= 2'd1;
                    end else if (req) begin
                        addr_q     <= addr_sum[ADDR_WIDTH-1:0] & ~ADDR_WIDTH'(3);
                        off_q      <= addr_sum[1:0];
                        f3_q       <= funct3;
                        is_store_q <= store;
                        wdata_q    <= st_data;
                        wstrb_q    <= store ? st_strb : 4'b0000;
                        valid_q    <= 1'b1;
                        tcnt       <= '0;
                        squash     <= 1'b0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (flush)
                        squash <= 1'b1;
                    if (bus.mem_ready) begin
                        valid_q <= 1'b0;
                        wstrb_q <= 4'b0000;
                        if (!is_store_q)
                            result <= ld_val;
                        // squashed transfers finish on the bus but never report done
                        if (squash || flush) begin
                            state <= IDLE;
                        end else begin
                            state <= RESP;
                            done  <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        valid_q     <= 1'b0;
                        wstrb_q     <= 4'b0000;
                        fault       <= 1'b1;
                        fault_cause <= 2'd3;
                        state       <= IDLE;
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                RESP: begin
                    if (!hlt) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_valid = valid_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wstrb = wstrb_q;
endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for lsu against a transaction-level model
module tb_lsu;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hlt = 1'b0;
    logic        flush = 1'b0;
    logic        load = 1'b0;
    logic        store = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] base = '0;
    logic [31:0] offset = '0;
    logic [31:0] wdata_in = '0;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic        fault;
    logic [1:0]  fault_cause;

    lsu_if #(.ADDR_WIDTH(32)) bus();

    lsu #(.ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst_n), .hlt(hlt), .flush(flush), .load(load), .store(store),
        .funct3(funct3), .base(base), .offset(offset), .wdata_in(wdata_in),
        .stall(stall), .done(done), .result(result), .fault(fault),
        .fault_cause(fault_cause), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall;
        logic        done;
        logic        fault;
        logic        valid;
        logic [1:0]  cause;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] result;
        logic [3:0]  wstrb;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        ce;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          issue_cyc = 0;
    int          done_cyc = -1;
    int          valid_cnt = 0;
    logic [31:0] done_res = '0;
    logic [1:0]  m_cause = '0;
    logic [31:0] m_result = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Model: rules of the access, in plain arithmetic
    function automatic logic [1:0] m_fault(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        if (st ? (f3 > 3'd2) : !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5))
            return 2'd2;
        sz = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        if (a % sz != 0)
            return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        logic [31:0] b;
        logic [31:0] h;
        v = rd >> (8 * (a % 4));
        b = v & 32'hFF;
        h = v & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 32'd256 : b;
            3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return v;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (f3 == 0) return (wd & 32'hFF) * 32'h01010101;
        if (f3 == 1) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 0) return 4'(1 << (a % 4));
        if (f3 == 1) return 4'(3 << (a % 4));
        return 4'hF;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.mem_valid) valid_cnt++;
        if (done) begin
            done_cyc = cyc;
            done_res = result;
        end
        if (exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            chk("stall", 32'(stall), 32'(ce.stall));
            chk("done", 32'(done), 32'(ce.done));
            chk("fault", 32'(fault), 32'(ce.fault));
            chk("fault_cause", 32'(fault_cause), 32'(ce.cause));
            chk("mem_valid", 32'(bus.mem_valid), 32'(ce.valid));
            if (ce.valid) begin
                chk("mem_addr", bus.mem_addr, ce.addr);
                chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(ce.wstrb));
                if (ce.wstrb != 0) chk("mem_wdata", bus.mem_wdata, ce.wdata);
            end
            if (ce.done) begin
                chk("result", result, ce.result);
                chk("resp_wstrb", 32'(bus.mem_wstrb), 32'd0);
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        #1;
    endtask

    // waits: not-ready BUSY cycles before ready (>= TO means never); flush_k: BUSY cycle to flush; hold: RESP hlt cycles
    task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] b, input logic [31:0] o, input logic [31:0] wd,
                          input logic [31:0] rd, input int waits, input int flush_k, input int hold);
        logic [31:0] a;
        logic [1:0]  c;
        int          nb;
        bit          tmo;
        exp_t        e;
        a = b + o;
        c = m_fault(st, f3, a);
        @(posedge clk); #1;
        load = ld; store = st; funct3 = f3; base = b; offset = o; wdata_in = wd;
        bus.mem_rdata = rd;
        issue_cyc = cyc;
        valid_cnt = 0;
        done_cyc = -1;
        e = '0;
        e.cause = m_cause;
        if (c != 0) begin
            exp_q.push_back(e);
            m_cause = c;
            e.fault = 1'b1; e.cause = c;
            exp_q.push_back(e);
            e.fault = 1'b0;
            exp_q.push_back(e);
            @(posedge clk); #1;
            load = 1'b0; store = 1'b0;
        end else begin
            tmo = (TO != 0) && (waits >= TO);
            nb = tmo ? TO : waits + 1;
            e.stall = 1'b1;
            exp_q.push_back(e);
            e.valid = 1'b1;
            e.addr  = a - (a % 4);
            e.wstrb = st ? m_strb(f3, a) : 4'h0;
            e.wdata = m_wdata(f3, wd);
            for (int k = 0; k < nb; k++) exp_q.push_back(e);
            e.valid = 1'b0; e.stall = 1'b0; e.wstrb = '0; e.addr = '0; e.wdata = '0;
            if (tmo) begin
                m_cause = 2'd3;
                e.fault = 1'b1; e.cause = 2'd3;
                exp_q.push_back(e);
                e.fault = 1'b0;
            end else if (flush_k < 0 || flush_k >= nb) begin
                if (!st) m_result = m_load(f3, a, rd);
                e.done = 1'b1; e.result = m_result;
                for (int i = 0; i <= hold; i++) exp_q.push_back(e);
                e.done = 1'b0;
            end
            exp_q.push_back(e);
            for (int k = 0; k < nb; k++) begin
                @(posedge clk); #1;
                bus.mem_ready = (k == waits);
                flush = (k == flush_k);
                hlt = (hold > 0);
            end
            @(posedge clk); #1;
            bus.mem_ready = 1'b0; flush = 1'b0; load = 1'b0; store = 1'b0;
            hlt = (hold > 0);
            for (int i = 1; i <= hold; i++) begin
                @(posedge clk); #1;
                hlt = (i < hold);
            end
        end
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got no end, expected end");
        $fatal(1);
    end

    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        #3;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_cause", 32'(fault_cause), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_valid", 32'(bus.mem_valid), 32'd0);
        chk("rst_wstrb", 32'(bus.mem_wstrb), 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // LW zero-wait
        run_op(1, 0, 3'd2, 32'h1000, 32'd4, 32'd0, 32'hDEADBEEF, 0, -1, 0);
        chk("lw_latency", 32'(done_cyc - issue_cyc), 32'd2);
        chk("lw_result", done_res, 32'hDEADBEEF);
        // sized loads with extension
        run_op(1, 0, 3'd0, 32'h1000, 32'd3, 32'd0, 32'h80AABBCC, 0, -1, 0);
        chk("lb_result", done_res, 32'hFFFFFF80);
        run_op(1, 0, 3'd4, 32'h1000, 32'd3, 32'd0, 32'h80AABBCC, 1, -1, 0);
        chk("lbu_result", done_res, 32'h00000080);
        run_op(1, 0, 3'd1, 32'h1000, 32'd2, 32'd0, 32'h80AABBCC, 0, -1, 0);
        chk("lh_result", done_res, 32'hFFFF80AA);
        run_op(1, 0, 3'd5, 32'h1004, 32'hFFFFFFFE, 32'd0, 32'h80AABBCC, 0, -1, 0);
        chk("lhu_result", done_res, 32'h000080AA);
        // stores with lane steering and wait states
        run_op(0, 1, 3'd1, 32'h2000, 32'd2, 32'h12345678, 32'd0, 3, -1, 0);
        chk("sh_latency", 32'(done_cyc - issue_cyc), 32'd5);
        run_op(0, 1, 3'd0, 32'h2001, 32'd0, 32'h000000AB, 32'd0, 0, -1, 0);
        run_op(0, 1, 3'd2, 32'h2008, 32'd0, 32'hCAFEF00D, 32'd0, 1, -1, 0);
        // faults: misaligned, illegal, and illegal taking priority
        run_op(1, 0, 3'd2, 32'h1000, 32'd1, 32'd0, 32'd0, 0, -1, 0);
        chk("misalign_no_bus", 32'(valid_cnt), 32'd0);
        chk("misalign_cause", 32'(fault_cause), 32'd1);
        run_op(0, 1, 3'd4, 32'h2000, 32'd0, 32'd0, 32'd0, 0, -1, 0);
        chk("illegal_cause", 32'(fault_cause), 32'd2);
        run_op(0, 1, 3'd5, 32'h2001, 32'd0, 32'd0, 32'd0, 0, -1, 0);
        run_op(1, 0, 3'd3, 32'h1000, 32'd0, 32'd0, 32'd0, 0, -1, 0);
        run_op(1, 0, 3'd1, 32'h1003, 32'd0, 32'd0, 32'd0, 0, -1, 0);
        // timeout abort and ready on the final allowed cycle
        run_op(1, 0, 3'd2, 32'h3000, 32'd0, 32'd0, 32'h11223344, 99, -1, 0);
        chk("tmo_valid_cycles", 32'(valid_cnt), 32'd4);
        chk("tmo_no_done", 32'(done_cyc), 32'hFFFFFFFF);
        run_op(1, 0, 3'd2, 32'h3000, 32'd0, 32'd0, 32'h11223344, 3, -1, 0);
        chk("tmo_edge_result", done_res, 32'h11223344);
        // flushed store still writes, no done
        run_op(0, 1, 3'd2, 32'h2004, 32'd0, 32'h55AA55AA, 32'd0, 2, 1, 0);
        chk("flush_no_done", 32'(done_cyc), 32'hFFFFFFFF);
        // hlt during BUSY and RESP holds done
        run_op(1, 0, 3'd0, 32'h1000, 32'd1, 32'd0, 32'h0000F700, 1, -1, 2);
        chk("hlt_done_last", 32'(done_cyc - issue_cyc), 32'd5);
        chk("hlt_result", done_res, 32'hFFFFFFF7);

        // asynchronous reset while BUSY
        @(posedge clk); #1;
        load = 1'b1; funct3 = 3'd2; base = 32'h3000; offset = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("busy_before_reset", 32'(bus.mem_valid), 32'd1);
        load = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("reset_valid_drop", 32'(bus.mem_valid), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_cause", 32'(fault_cause), 32'd0);
        m_cause = '0;
        m_result = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(1, 0, 3'd2, 32'h1000, 32'd8, 32'd0, 32'h0BADF00D, 0, -1, 0);
        chk("post_reset_result", done_res, 32'h0BADF00D);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
